// File: rtl/mx_pe_pkg.sv
// Shared types and constants for the MX Block_PE job sequencer.
package mx_pe_pkg;

  localparam int SEXP_W = 8;
  localparam int MODE_W = 6;
  localparam int TMR_W  = 8;

  localparam logic [1:0] PREC_INT8 = 2'd0;
  localparam logic [1:0] PREC_INT4 = 2'd1;
  localparam logic [1:0] PREC_INT2 = 2'd2;
  localparam logic [1:0] PREC_FP8  = 2'd3;

  localparam logic [1:0] FP_E5M2 = 2'd0;
  localparam logic [1:0] FP_E4M3 = 2'd1;
  localparam logic [1:0] FP_E3M2 = 2'd2;
  localparam logic [1:0] FP_E2M3 = 2'd3;

  // Packed job mode as handed to the PE.
  typedef struct packed {
    logic [1:0] prec;
    logic [1:0] fp;
    logic       prec_q;
    logic       fp_q;
  } mx_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_QUANT,
    ST_OUT
  } seq_state_e;

endpackage

// File: rtl/mx_op_buf.sv
// One-entry operand buffer (payload + shared exponent). Push and pop in the same
// cycle keep the entry full, which gives one operand per cycle of throughput.
module mx_op_buf
  import mx_pe_pkg::*;
#(
  parameter int W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      wr_data,
  input  logic [SEXP_W-1:0] wr_sexp,
  output logic              full,
  output logic [W-1:0]      rd_data,
  output logic [SEXP_W-1:0] rd_sexp
);

  // Occupancy flag: push wins over pop so a simultaneous pop/push stays full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // Payload storage, written on every accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      rd_sexp <= '0;
    end else if (push) begin
      rd_data <= wr_data;
      rd_sexp <= wr_sexp;
    end
  end

endmodule

// File: rtl/mx_block_pe_seq.sv
// Job sequencer for one MX Block_PE tile: config accept, K operand-pair issue,
// PE drain, requantise and result hand-off.
//
// state    | meaning
// ST_IDLE  | waiting for a job config
// ST_LOAD  | clearing PE, accepting A/B beats and issuing pairs
// ST_DRAIN | waiting PE_LAT cycles for the last MAC to settle
// ST_QUANT | pe_send_output_o held for QUAN_LAT cycles, result captured on the last
// ST_OUT   | result presented until consumed
module mx_block_pe_seq
  import mx_pe_pkg::*;
#(
  parameter int A_W      = 512,
  parameter int B_W      = 512,
  parameter int OUT_W    = 512,
  parameter int K_CNT_W  = 8,
  parameter int PE_LAT   = 2,
  parameter int QUAN_LAT = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [MODE_W-1:0]  cfg_prec_i,
  input  logic [K_CNT_W-1:0] cfg_k_i,
  input  logic               a_valid_i,
  output logic               a_ready_o,
  input  logic [A_W-1:0]     a_data_i,
  input  logic [SEXP_W-1:0]  a_sexp_i,
  input  logic               b_valid_i,
  output logic               b_ready_o,
  input  logic [B_W-1:0]     b_data_i,
  input  logic [SEXP_W-1:0]  b_sexp_i,
  output logic               pe_clear_o,
  output logic               pe_issue_o,
  output logic [A_W-1:0]     pe_a_o,
  output logic [B_W-1:0]     pe_b_o,
  output logic [SEXP_W-1:0]  pe_sexp_a_o,
  output logic [SEXP_W-1:0]  pe_sexp_b_o,
  output logic [MODE_W-1:0]  pe_mode_o,
  output logic               pe_send_output_o,
  input  logic [OUT_W-1:0]   pe_out_i,
  input  logic [SEXP_W-1:0]  pe_sexp_out_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W-1:0]   out_data_o,
  output logic [SEXP_W-1:0]  out_sexp_o,
  output logic               busy_o
);

  seq_state_e         state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [K_CNT_W-1:0] k_q, a_cnt, b_cnt, issue_cnt;
  mx_mode_t           mode_q;
  logic               init_done;
  logic               a_full, b_full, a_push, b_push, issue, cfg_fire, cap;

  assign cfg_fire  = cfg_valid_i & cfg_ready_o;
  assign issue     = (state == ST_LOAD) & a_full & b_full & ~pe_clear_o;
  assign a_ready_o = (state == ST_LOAD) & (a_cnt < k_q) & (~a_full | issue);
  assign b_ready_o = (state == ST_LOAD) & (b_cnt < k_q) & (~b_full | issue);
  assign a_push    = a_valid_i & a_ready_o;
  assign b_push    = b_valid_i & b_ready_o;
  assign cap       = (state == ST_QUANT) & (tmr == '0);

  // cfg_ready stays low during the first cycle after reset release.
  assign cfg_ready_o      = (state == ST_IDLE) & init_done;
  assign busy_o           = (state != ST_IDLE);
  assign out_valid_o      = (state == ST_OUT);
  assign pe_send_output_o = (state == ST_QUANT);
  assign pe_issue_o       = issue;
  assign pe_mode_o        = mode_q;

  mx_op_buf #(.W(A_W)) u_a_buf (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (a_push),
    .pop     (issue),
    .wr_data (a_data_i),
    .wr_sexp (a_sexp_i),
    .full    (a_full),
    .rd_data (pe_a_o),
    .rd_sexp (pe_sexp_a_o)
  );

  mx_op_buf #(.W(B_W)) u_b_buf (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (b_push),
    .pop     (issue),
    .wr_data (b_data_i),
    .wr_sexp (b_sexp_i),
    .full    (b_full),
    .rd_data (pe_b_o),
    .rd_sexp (pe_sexp_b_o)
  );

  // State and latency timer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next-state logic; the timer is a down-counter loaded on entry to DRAIN/QUANT.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      ST_IDLE:  if (cfg_fire) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (issue && (issue_cnt == k_q - 1'b1)) begin
          state_nxt = ST_DRAIN;
          tmr_nxt   = TMR_W'(PE_LAT - 1);
        end
      end
      ST_DRAIN: begin
        if (tmr == '0) begin
          state_nxt = ST_QUANT;
          tmr_nxt   = TMR_W'(QUAN_LAT - 1);
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      ST_QUANT: begin
        if (tmr == '0) state_nxt = ST_OUT;
        else           tmr_nxt   = tmr - 1'b1;
      end
      ST_OUT:   if (out_ready_i) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Job config, beat counters and the one-cycle PE clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_done  <= 1'b0;
      mode_q     <= '0;
      k_q        <= '0;
      a_cnt      <= '0;
      b_cnt      <= '0;
      issue_cnt  <= '0;
      pe_clear_o <= 1'b0;
    end else begin
      init_done  <= 1'b1;
      pe_clear_o <= cfg_fire;
      if (cfg_fire) begin
        mode_q    <= mx_mode_t'(cfg_prec_i);
        k_q       <= (cfg_k_i == '0) ? K_CNT_W'(1) : cfg_k_i;
        a_cnt     <= '0;
        b_cnt     <= '0;
        issue_cnt <= '0;
      end else begin
        if (a_push) a_cnt     <= a_cnt + 1'b1;
        if (b_push) b_cnt     <= b_cnt + 1'b1;
        if (issue)  issue_cnt <= issue_cnt + 1'b1;
      end
    end
  end

  // Result register, loaded on the last requantise cycle and held through OUT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_o <= '0;
      out_sexp_o <= '0;
    end else if (cap) begin
      out_data_o <= pe_out_i;
      out_sexp_o <= pe_sexp_out_i;
    end
  end

endmodule

// File: tb/tb_mx_block_pe_seq.sv
// Self-checking bench for mx_block_pe_seq with a behavioural PE behind it.
// The PE model accumulates (A xor B) and (sexp_a + sexp_b) with PE_LAT latency and
// mixes the job mode into its result, so mode latching and beat ordering are visible.
module tb_mx_block_pe_seq;
  import mx_pe_pkg::*;

  localparam int A_W      = 512;
  localparam int B_W      = 512;
  localparam int OUT_W    = 512;
  localparam int K_CNT_W  = 8;
  localparam int PE_LAT   = 2;
  localparam int QUAN_LAT = 1;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [7:0]       s;
  } exp_t;

  logic               clk, rst;
  logic               cfg_valid, cfg_ready;
  logic [5:0]         cfg_prec;
  logic [K_CNT_W-1:0] cfg_k;
  logic               a_valid, a_ready, b_valid, b_ready;
  logic [A_W-1:0]     a_data;
  logic [B_W-1:0]     b_data;
  logic [7:0]         a_sexp, b_sexp;
  logic               pe_clear, pe_issue, pe_send;
  logic [A_W-1:0]     pe_a;
  logic [B_W-1:0]     pe_b;
  logic [7:0]         pe_sexp_a, pe_sexp_b, pe_sexp_out;
  logic [5:0]         pe_mode;
  logic [OUT_W-1:0]   pe_out;
  logic               out_valid, out_ready, busy;
  logic [OUT_W-1:0]   out_data;
  logic [7:0]         out_sexp;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_issue = 0;
  int   n_issue  = 0;
  exp_t sb[$];

  logic [OUT_W-1:0] m_acc;
  logic [7:0]       m_sacc;

  mx_block_pe_seq #(
    .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .K_CNT_W(K_CNT_W),
    .PE_LAT(PE_LAT), .QUAN_LAT(QUAN_LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_prec_i(cfg_prec), .cfg_k_i(cfg_k),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data), .a_sexp_i(a_sexp),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data), .b_sexp_i(b_sexp),
    .pe_clear_o(pe_clear), .pe_issue_o(pe_issue),
    .pe_a_o(pe_a), .pe_b_o(pe_b),
    .pe_sexp_a_o(pe_sexp_a), .pe_sexp_b_o(pe_sexp_b),
    .pe_mode_o(pe_mode), .pe_send_output_o(pe_send),
    .pe_out_i(pe_out), .pe_sexp_out_i(pe_sexp_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_sexp_o(out_sexp),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE: not reset, so only pe_clear_o gives it a clean start.
  logic [OUT_W-1:0] pe_acc = '0, pe_stage = '0;
  logic [7:0]       pe_sacc = '0, pe_sstage = '0;
  logic             pe_stage_v = 1'b0;

  always @(posedge clk) begin
    pe_stage_v <= pe_issue;
    if (pe_issue) begin
      pe_stage  <= {{(OUT_W-A_W){1'b0}}, pe_a ^ pe_b};
      pe_sstage <= pe_sexp_a + pe_sexp_b;
    end
    if (pe_clear) begin
      pe_acc  <= '0;
      pe_sacc <= '0;
    end else if (pe_stage_v) begin
      pe_acc  <= pe_acc + pe_stage;
      pe_sacc <= pe_sacc + pe_sstage;
    end
  end

  assign pe_out      = pe_send ? (pe_acc ^ {(OUT_W/8){{2'b00, pe_mode}}}) : '0;
  assign pe_sexp_out = pe_send ? (pe_sacc ^ {2'b00, pe_mode}) : '0;

  // Cycle counter and issue monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pe_issue) begin
      last_issue <= cyc;
      n_issue    <= n_issue + 1;
    end
  end

  task automatic check(input string tag, input logic [OUT_W-1:0] got,
                       input logic [OUT_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [A_W-1:0] rnd_blk();
    logic [A_W-1:0] v;
    for (int i = 0; i < A_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_job(input logic [5:0] mode, input logic [K_CNT_W-1:0] k);
    logic r;
    bit   ok = 0;
    cfg_valid = 1'b1;
    cfg_prec  = mode;
    cfg_k     = k;
    for (int t = 0; t < 50; t++) begin
      r = cfg_ready;
      tick();
      if (r) begin ok = 1; break; end
    end
    cfg_valid = 1'b0;
    if (!ok) check("cfg_timeout", 0, 1);
    m_acc  = '0;
    m_sacc = '0;
  endtask

  task automatic drive_a(input logic [A_W-1:0] d, input logic [7:0] s);
    logic r;
    bit   ok = 0;
    a_valid = 1'b1; a_data = d; a_sexp = s;
    for (int t = 0; t < 50; t++) begin
      r = a_ready;
      tick();
      if (r) begin ok = 1; break; end
    end
    a_valid = 1'b0;
    if (!ok) check("a_timeout", 0, 1);
  endtask

  task automatic drive_b(input logic [B_W-1:0] d, input logic [7:0] s);
    logic r;
    bit   ok = 0;
    b_valid = 1'b1; b_data = d; b_sexp = s;
    for (int t = 0; t < 50; t++) begin
      r = b_ready;
      tick();
      if (r) begin ok = 1; break; end
    end
    b_valid = 1'b0;
    if (!ok) check("b_timeout", 0, 1);
  endtask

  // One A/B pair; skew 0 offers both together, otherwise B follows A by skew cycles.
  task automatic drive_pair(input logic [A_W-1:0] da, input logic [7:0] sa,
                            input logic [B_W-1:0] db, input logic [7:0] sb_e,
                            input int skew);
    logic ra, rb;
    if (skew == 0) begin
      a_valid = 1'b1; a_data = da; a_sexp = sa;
      b_valid = 1'b1; b_data = db; b_sexp = sb_e;
      for (int t = 0; t < 50 && (a_valid || b_valid); t++) begin
        ra = a_valid & a_ready;
        rb = b_valid & b_ready;
        tick();
        if (ra) a_valid = 1'b0;
        if (rb) b_valid = 1'b0;
      end
      if (a_valid || b_valid) check("pair_timeout", 0, 1);
      a_valid = 1'b0;
      b_valid = 1'b0;
    end else begin
      drive_a(da, sa);
      for (int i = 0; i < skew - 1; i++) begin
        check("a_ready_held", a_ready, 0);
        tick();
      end
      drive_b(db, sb_e);
    end
    m_acc  = m_acc + (da ^ db);
    m_sacc = m_sacc + sa + sb_e;
  endtask

  task automatic push_exp(input logic [5:0] mode);
    exp_t e;
    e.d = m_acc ^ {(OUT_W/8){{2'b00, mode}}};
    e.s = m_sacc ^ {2'b00, mode};
    sb.push_back(e);
  endtask

  task automatic collect(input int stall, input bit chk_lat);
    exp_t e;
    bit   seen = 0;
    out_ready = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (out_valid) begin seen = 1; break; end
      tick();
    end
    if (!seen) begin
      check("out_timeout", 0, 1);
      return;
    end
    if (chk_lat) check("latency", cyc - last_issue, PE_LAT + QUAN_LAT + 1);
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, e.d);
      check("stall_cfg_ready", cfg_ready, 0);
      tick();
    end
    check("out_data", out_data, e.d);
    check("out_sexp", out_sexp, e.s);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("busy_drop", busy, 0);
  endtask

  initial begin
    mx_mode_t   m_e4m3;
    logic [5:0] m_int8;
    m_int8 = '0;
    m_e4m3 = '{prec: PREC_FP8, fp: FP_E4M3, prec_q: 1'b0, fp_q: 1'b0};

    rst = 1'b1;
    cfg_valid = 0; cfg_prec = '0; cfg_k = '0;
    a_valid = 0; a_data = '0; a_sexp = '0;
    b_valid = 0; b_data = '0; b_sexp = '0;
    out_ready = 0;
    repeat (3) tick();

    // Reset state.
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_send", pe_send, 0);
    check("rst_out_data", out_data, '0);
    rst = 1'b0;
    #1;
    check("rel_cfg_ready", cfg_ready, 0);
    tick();
    check("idle_cfg_ready", cfg_ready, 1);

    // INT8, K=1, constant operands, same-cycle A/B.
    start_job(m_int8, 8'd1);
    check("load_clear", pe_clear, 1);
    check("load_busy", busy, 1);
    drive_pair({64{8'd11}}, 8'd127, {64{8'd8}}, 8'd127, 0);
    push_exp(m_int8);
    collect(0, 1);

    // K=4 with A three cycles ahead of B on every beat.
    n_issue = 0;
    start_job(m_int8, 8'd4);
    for (int i = 0; i < 4; i++)
      drive_pair(rnd_blk(), 8'($urandom), rnd_blk(), 8'($urandom), 3);
    push_exp(m_int8);
    collect(0, 0);
    check("k4_issues", n_issue, 4);

    // E4M3, K=1, negative-looking A bytes.
    start_job(6'(m_e4m3), 8'd1);
    check("mode_latched", pe_mode, 6'(m_e4m3));
    drive_pair({64{8'hF5}}, 8'd120, {64{8'd8}}, 8'd121, 0);
    push_exp(6'(m_e4m3));
    collect(0, 1);

    // Output back-pressure for five cycles.
    start_job(m_int8, 8'd2);
    for (int i = 0; i < 2; i++)
      drive_pair(rnd_blk(), 8'($urandom), rnd_blk(), 8'($urandom), 0);
    push_exp(m_int8);
    collect(5, 0);

    // K=0 behaves as K=1; a second A beat is refused.
    n_issue = 0;
    start_job(m_int8, 8'd0);
    drive_pair(rnd_blk(), 8'd3, rnd_blk(), 8'd4, 0);
    a_valid = 1'b1;
    #1;
    check("k0_extra_a", a_ready, 0);
    a_valid = 1'b0;
    push_exp(m_int8);
    collect(0, 0);
    check("k0_issues", n_issue, 1);

    // K=4 back-to-back pairs, then a 5th A beat that must not be accepted.
    n_issue = 0;
    start_job(m_int8, 8'd4);
    for (int i = 0; i < 4; i++)
      drive_pair(rnd_blk(), 8'($urandom), rnd_blk(), 8'($urandom), 0);
    a_valid = 1'b1;
    a_data  = rnd_blk();
    for (int i = 0; i < 3; i++) begin
      check("fifth_a_ready", a_ready, 0);
      tick();
    end
    a_valid = 1'b0;
    push_exp(m_int8);
    collect(0, 0);
    check("k4b_issues", n_issue, 4);

    // Reset in the middle of LOAD after two issues.
    n_issue = 0;
    start_job(m_int8, 8'd4);
    for (int i = 0; i < 2; i++)
      drive_pair(rnd_blk(), 8'($urandom), rnd_blk(), 8'($urandom), 0);
    tick();
    check("pre_rst_issues", n_issue, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cfg_ready", cfg_ready, 0);
    check("mid_rst_a_ready", a_ready, 0);
    check("mid_rst_mode", pe_mode, 0);
    check("mid_rst_out_valid", out_valid, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    start_job(m_int8, 8'd1);
    drive_pair({64{8'd11}}, 8'd127, {64{8'd8}}, 8'd127, 0);
    push_exp(m_int8);
    collect(0, 1);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
